// File: rtl/riot_timer_pkg.sv
// rtl/riot_timer_pkg.sv - register offsets, interval codes and prescaler helpers for riot_timer
package riot_timer_pkg;

  // Register offsets as seen on A[3:0]; bit 3 on a timer write is the IRQ enable
  localparam logic [3:0] OFF_TIM1T  = 4'h4;
  localparam logic [3:0] OFF_TIM8T  = 4'h5;
  localparam logic [3:0] OFF_TIM64T = 4'h6;
  localparam logic [3:0] OFF_T1024T = 4'h7;
  localparam logic [3:0] OFF_INTIM  = 4'h4;
  localparam logic [3:0] OFF_TIMINT = 4'h5;
  localparam int         IRQ_EN_BIT = 3;

  // Interval select code, taken from A[1:0] on a timer write
  typedef enum logic [1:0] {
    SEL_1T    = 2'd0,
    SEL_8T    = 2'd1,
    SEL_64T   = 2'd2,
    SEL_1024T = 2'd3
  } interval_sel_t;

  // Prescaler reload value: interval length minus one
  function automatic int unsigned interval_last(input interval_sel_t sel);
    case (sel)
      SEL_1T:  interval_last = 0;
      SEL_8T:  interval_last = 7;
      SEL_64T: interval_last = 63;
      default: interval_last = 1023;
    endcase
  endfunction

endpackage

// File: rtl/riot_timer_prescaler.sv
// rtl/riot_timer_prescaler.sv - interval down-counter producing one tick per interval
module riot_timer_prescaler
  import riot_timer_pkg::*;
#(
  parameter int DIV_W = 10
) (
  input  logic          i_clk,
  input  logic          i_res_n,
  input  logic          i_load,
  input  interval_sel_t i_interval_sel,
  input  logic          i_fast,
  output logic          o_tick
);

  logic [DIV_W-1:0] r_cnt;
  interval_sel_t    r_sel;

  assign o_tick = (r_cnt == '0);

  // Load restarts the interval; on a tick reload, or stay at zero while in post-underflow fast mode
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_cnt <= DIV_W'(interval_last(SEL_1024T));
      r_sel <= SEL_1024T;
    end else if (i_load) begin
      r_cnt <= DIV_W'(interval_last(i_interval_sel));
      r_sel <= i_interval_sel;
    end else if (o_tick) begin
      r_cnt <= i_fast ? '0 : DIV_W'(interval_last(r_sel));
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/riot_timer.sv
// rtl/riot_timer.sv - 6532-style 8-bit interval timer with prescaler, underflow flag and IRQ
module riot_timer
  import riot_timer_pkg::*;
#(
  parameter logic [7:0] RESET_COUNT = 8'hFF,
  parameter int         DIV_W       = 10
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_cs,
  input  logic [3:0] i_a,
  input  logic       i_we,
  input  logic [7:0] i_wd,
  output logic [7:0] o_rd,
  output logic       o_irq_n
);

  logic [7:0]    r_intim;
  logic          r_flag;
  logic          r_irq_en;
  logic          r_fast;

  logic          w_timer_wr;
  logic          w_intim_rd;
  logic          w_tick;
  logic          w_underflow;
  interval_sel_t w_sel;
  logic [7:0]    w_intim_next;
  logic          w_flag_next;
  logic          w_irq_en_next;
  logic          w_fast_next;

  // Any write with A[2] set is a timer load; A[3] carries the IRQ enable
  assign w_timer_wr  = i_cs & i_we & i_a[2];
  assign w_intim_rd  = i_cs & ~i_we & (i_a[2:0] == OFF_INTIM[2:0]);
  assign w_sel       = interval_sel_t'(i_a[1:0]);
  assign w_underflow = w_tick & ~w_timer_wr & (r_intim == 8'h00);

  riot_timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_clk          (i_clk),
    .i_res_n        (i_res_n),
    .i_load         (w_timer_wr),
    .i_interval_sel (w_sel),
    .i_fast         (w_fast_next),
    .o_tick         (w_tick)
  );

  // Next-state: a write beats a tick, and an underflow beats the read-clear of the flag
  always_comb begin
    w_intim_next  = r_intim;
    w_flag_next   = r_flag;
    w_irq_en_next = r_irq_en;
    w_fast_next   = r_fast;
    if (w_timer_wr) begin
      w_intim_next  = i_wd;
      w_flag_next   = 1'b0;
      w_irq_en_next = i_a[IRQ_EN_BIT];
      w_fast_next   = 1'b0;
    end else begin
      if (w_tick) begin
        w_intim_next = r_intim - 8'd1;
      end
      if (w_underflow) begin
        w_flag_next = 1'b1;
        w_fast_next = 1'b1;
      end else if (w_intim_rd) begin
        w_flag_next = 1'b0;
      end
    end
  end

  // Timer state and registered IRQ output
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_intim  <= RESET_COUNT;
      r_flag   <= 1'b0;
      r_irq_en <= 1'b0;
      r_fast   <= 1'b0;
      o_irq_n  <= 1'b1;
    end else begin
      r_intim  <= w_intim_next;
      r_flag   <= w_flag_next;
      r_irq_en <= w_irq_en_next;
      r_fast   <= w_fast_next;
      o_irq_n  <= ~(w_flag_next & w_irq_en_next);
    end
  end

  // Read mux: only INTIM and TIMINT return data, everything else reads as zero
  always_comb begin
    o_rd = 8'h00;
    if (i_cs) begin
      if (i_a[2:0] == OFF_INTIM[2:0]) begin
        o_rd = r_intim;
      end else if (i_a[2:0] == OFF_TIMINT[2:0]) begin
        o_rd = {r_flag, 7'b0};
      end
    end
  end

endmodule

// File: tb/tb_riot_timer.sv
// tb/tb_riot_timer.sv - directed self-checking bench for riot_timer
module tb_riot_timer;

  logic       i_clk;
  logic       i_res_n;
  logic       i_cs;
  logic [3:0] i_a;
  logic       i_we;
  logic [7:0] i_wd;
  logic [7:0] o_rd;
  logic       o_irq_n;

  int tests_run;
  int tests_failed;

  riot_timer u_dut (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_cs    (i_cs),
    .i_a     (i_a),
    .i_we    (i_we),
    .i_wd    (i_wd),
    .o_rd    (o_rd),
    .o_irq_n (o_irq_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance n rising edges, leaving time 1 ns after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Bus write taking effect on the next rising edge
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_a = a; i_wd = d;
    @(posedge i_clk);
    #1;
    i_cs = 1'b0; i_we = 1'b0; i_a = 4'h0; i_wd = 8'h00;
  endtask

  // Side-effect-free look at a register: the select is dropped before the next edge
  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b0; i_a = a;
    #1;
    d = o_rd;
    i_cs = 1'b0; i_a = 4'h0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    i_res_n = 1'b0; i_cs = 1'b0; i_we = 1'b0; i_a = 4'h0; i_wd = 8'h00;
    #12;
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL reset_intim got %h exp ff", d); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_timint got %h exp 00", d); end
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL reset_irq_n got %b exp 1", o_irq_n); end
    peek(4'h7, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_unmapped got %h exp 00", d); end
    @(posedge i_clk);
    #1;
    i_res_n = 1'b1;
    step(1023);
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL reset_hold_1023 got %h exp ff", d); end
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL reset_irq_n_1023 got %b exp 1", o_irq_n); end
    step(1);
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFE) begin tests_failed++; $display("FAIL reset_first_dec got %h exp fe", d); end
  endtask

  task automatic test_tim8t;
    logic [7:0] d;
    logic [7:0] exp_cnt;
    logic [7:0] exp_flag;
    bus_write(4'h5, 8'h05);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h05) begin tests_failed++; $display("FAIL tim8t_k0 got %h exp 05", d); end
    for (int k = 1; k <= 49; k++) begin
      step(1);
      exp_cnt  = (k < 48) ? 8'(5 - k / 8) : 8'(255 - (k - 48));
      exp_flag = (k < 48) ? 8'h00 : 8'h80;
      peek(4'h4, d);
      tests_run++; if (d !== exp_cnt) begin tests_failed++; $display("FAIL tim8t_intim k=%0d got %h exp %h", k, d, exp_cnt); end
      peek(4'hD, d);
      tests_run++; if (d !== exp_flag) begin tests_failed++; $display("FAIL tim8t_timint k=%0d got %h exp %h", k, d, exp_flag); end
    end
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL tim8t_irq_disabled got %b exp 1", o_irq_n); end
  endtask

  task automatic test_irq;
    logic [7:0] d;
    bus_write(4'hF, 8'h02);
    step(3071);
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL irq_early got %b exp 1", o_irq_n); end
    peek(4'h4, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL irq_pre_intim got %h exp 00", d); end
    step(1);
    tests_run++; if (o_irq_n !== 1'b0) begin tests_failed++; $display("FAIL irq_fall got %b exp 0", o_irq_n); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h80) begin tests_failed++; $display("FAIL irq_timint got %h exp 80", d); end
    i_cs = 1'b1; i_we = 1'b0; i_a = 4'h4;
    step(1);
    i_cs = 1'b0; i_a = 4'h0;
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL irq_clear got %b exp 1", o_irq_n); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL irq_clear_timint got %h exp 00", d); end
  endtask

  task automatic test_underflow_vs_read;
    logic [7:0] d;
    bus_write(4'h4, 8'h01);
    step(1);
    i_cs = 1'b1; i_we = 1'b0; i_a = 4'h4;
    #1;
    d = o_rd;
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL uvr_pre got %h exp 00", d); end
    @(posedge i_clk);
    #1;
    i_cs = 1'b0; i_a = 4'h0;
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL uvr_intim got %h exp ff", d); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h80) begin tests_failed++; $display("FAIL uvr_timint got %h exp 80", d); end
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL uvr_irq_n got %b exp 1", o_irq_n); end
  endtask

  task automatic test_write_zero;
    logic [7:0] d;
    bus_write(4'h4, 8'h00);
    step(1);
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL wz_intim got %h exp ff", d); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h80) begin tests_failed++; $display("FAIL wz_timint got %h exp 80", d); end
    bus_write(4'h6, 8'h10);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h10) begin tests_failed++; $display("FAIL wz_reload got %h exp 10", d); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL wz_flag_clr got %h exp 00", d); end
    step(63);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h10) begin tests_failed++; $display("FAIL wz_64_hold got %h exp 10", d); end
    step(1);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h0F) begin tests_failed++; $display("FAIL wz_64_dec got %h exp 0f", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    bus_write(4'h5, 8'h03);
    bus_write(4'h4, 8'h07);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h07) begin tests_failed++; $display("FAIL b2b_load got %h exp 07", d); end
    step(1);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h06) begin tests_failed++; $display("FAIL b2b_dec got %h exp 06", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    bus_write(4'hC, 8'h00);
    step(1);
    tests_run++; if (o_irq_n !== 1'b0) begin tests_failed++; $display("FAIL rm_irq_set got %b exp 0", o_irq_n); end
    step(204);
    peek(4'h4, d);
    tests_run++; if (d !== 8'h33) begin tests_failed++; $display("FAIL rm_pre_intim got %h exp 33", d); end
    #2;
    i_res_n = 1'b0;
    #1;
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL rm_intim got %h exp ff", d); end
    tests_run++; if (o_irq_n !== 1'b1) begin tests_failed++; $display("FAIL rm_irq_n got %b exp 1", o_irq_n); end
    peek(4'h5, d);
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rm_timint got %h exp 00", d); end
    @(posedge i_clk);
    #1;
    i_res_n = 1'b1;
    step(2);
    peek(4'h4, d);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL rm_no_fast got %h exp ff", d); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_tim8t();
    test_irq();
    test_underflow_vs_read();
    test_write_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
